// File: rtl/branch_resolution_tracker_if.sv
// rtl/branch_resolution_tracker_if.sv - fetch/execute/predictor signal bundle for the branch resolution tracker
interface branch_resolution_tracker_if #(
    parameter int PC_W = 32
);
    logic            pred_valid;
    logic [PC_W-1:0] pred_pc;
    logic            pred_taken;
    logic [PC_W-1:0] pred_target;
    logic            pred_stall;
    logic            res_valid;
    logic            res_taken;
    logic [PC_W-1:0] res_target;
    logic            pipe_flush;
    logic            update_valid;
    logic [PC_W-1:0] update_pc;
    logic            update_taken;
    logic [PC_W-1:0] update_target;
    logic            mispredict;
    logic [PC_W-1:0] redirect_pc;
    logic            underflow_err;

    modport master (
        output pred_valid, pred_pc, pred_taken, pred_target,
        output res_valid, res_taken, res_target, pipe_flush,
        input  pred_stall, update_valid, update_pc, update_taken, update_target,
        input  mispredict, redirect_pc, underflow_err
    );

    modport slave (
        input  pred_valid, pred_pc, pred_taken, pred_target,
        input  res_valid, res_taken, res_target, pipe_flush,
        output pred_stall, update_valid, update_pc, update_taken, update_target,
        output mispredict, redirect_pc, underflow_err
    );
endinterface

// File: rtl/branch_resolution_tracker.sv
// rtl/branch_resolution_tracker.sv - in-order prediction queue checked against execute resolutions
module branch_resolution_tracker #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input logic                         clk,
    input logic                         rst,
    branch_resolution_tracker_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [PC_W-1:0] pc_mem    [DEPTH];
    logic            taken_mem [DEPTH];
    logic [PC_W-1:0] tgt_mem   [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic            empty;
    logic            full;
    logic            do_pop;
    logic            do_push;
    logic            underflow;
    logic            mismatch;
    logic            redirect;
    logic            clear;
    logic [PC_W-1:0] head_pc;
    logic [PC_W-1:0] head_tgt;
    logic            head_taken;

    logic            update_valid_q;
    logic [PC_W-1:0] update_pc_q;
    logic            update_taken_q;
    logic [PC_W-1:0] update_target_q;
    logic            mispredict_q;
    logic [PC_W-1:0] redirect_pc_q;
    logic            underflow_err_q;

    always_comb begin
        empty      = (count == '0);
        full       = (count == CW'(DEPTH));
        head_pc    = pc_mem[rd_ptr];
        head_taken = taken_mem[rd_ptr];
        head_tgt   = tgt_mem[rd_ptr];
        do_pop     = bus.res_valid && !empty;
        underflow  = bus.res_valid && empty;
        // Predicted target only matters when both sides agree the branch is taken.
        mismatch   = (head_taken != bus.res_taken) ||
                     (head_taken && bus.res_taken && (head_tgt != bus.res_target));
        redirect   = do_pop && mismatch && !bus.pipe_flush;
        clear      = bus.pipe_flush || redirect;
        // A pop frees the slot on the same edge, so a full queue can still accept.
        do_push    = bus.pred_valid && (!full || do_pop) && !clear;
    end

    assign bus.pred_stall = full;

    always_ff @(posedge clk) begin
        if (do_push) begin
            pc_mem[wr_ptr]    <= bus.pred_pc;
            taken_mem[wr_ptr] <= bus.pred_taken;
            tgt_mem[wr_ptr]   <= bus.pred_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= wr_ptr;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            if (do_push && !do_pop)      count <= count + CW'(1);
            else if (!do_push && do_pop) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            update_valid_q  <= 1'b0;
            update_pc_q     <= '0;
            update_taken_q  <= 1'b0;
            update_target_q <= '0;
            mispredict_q    <= 1'b0;
            redirect_pc_q   <= '0;
            underflow_err_q <= 1'b0;
        end else begin
            update_valid_q  <= do_pop;
            mispredict_q    <= redirect;
            underflow_err_q <= underflow_err_q || underflow;
            if (do_pop) begin
                update_pc_q     <= head_pc;
                update_taken_q  <= bus.res_taken;
                update_target_q <= bus.res_target;
            end
            if (redirect) begin
                redirect_pc_q <= bus.res_taken ? bus.res_target : head_pc + PC_W'(4);
            end
        end
    end

    assign bus.update_valid  = update_valid_q;
    assign bus.update_pc     = update_pc_q;
    assign bus.update_taken  = update_taken_q;
    assign bus.update_target = update_target_q;
    assign bus.mispredict    = mispredict_q;
    assign bus.redirect_pc   = redirect_pc_q;
    assign bus.underflow_err = underflow_err_q;
endmodule

// File: tb/tb_branch_resolution_tracker.sv
// tb/tb_branch_resolution_tracker.sv - scoreboard bench for branch_resolution_tracker
module tb_branch_resolution_tracker;
    logic clk;
    logic rst;

    branch_resolution_tracker_if #(.PC_W(32)) bus ();

    branch_resolution_tracker #(.DEPTH(4), .PC_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
        logic        mp;
        logic [31:0] redir;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic exp_stall;
    logic exp_uerr;
    logic done     = 1'b0;
    logic finished = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            chk("reset_flags", {28'd0, bus.update_valid, bus.mispredict, bus.pred_stall, bus.underflow_err}, 32'd0);
            chk("reset_update_pc", bus.update_pc, 32'd0);
            chk("reset_redirect_pc", bus.redirect_pc, 32'd0);
        end else begin
            chk("pred_stall", {31'd0, bus.pred_stall}, {31'd0, exp_stall});
            chk("underflow_err", {31'd0, bus.underflow_err}, {31'd0, exp_uerr});
            if (bus.update_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL stray_update: update_valid=1 pc=%h with nothing expected", bus.update_pc);
                end else begin
                    e = sb.pop_front();
                    chk("update_pc", bus.update_pc, e.pc);
                    chk("update_taken", {31'd0, bus.update_taken}, {31'd0, e.taken});
                    chk("update_target", bus.update_target, e.tgt);
                    chk("mispredict", {31'd0, bus.mispredict}, {31'd0, e.mp});
                    if (e.mp) chk("redirect_pc", bus.redirect_pc, e.redir);
                end
            end else begin
                chk("stray_mispredict", {31'd0, bus.mispredict}, 32'd0);
            end
        end
        if (done && !finished) begin
            chk("pending_updates", sb.size(), 32'd0);
            finished = 1'b1;
        end
    end

    task automatic idle_inputs();
        bus.pred_valid  = 1'b0;
        bus.pred_pc     = '0;
        bus.pred_taken  = 1'b0;
        bus.pred_target = '0;
        bus.res_valid   = 1'b0;
        bus.res_taken   = 1'b0;
        bus.res_target  = '0;
        bus.pipe_flush  = 1'b0;
    endtask

    task automatic step(input logic pv, input logic [31:0] ppc, input logic pt, input logic [31:0] ptg,
                        input logic rv, input logic rt, input logic [31:0] rtg, input logic fl);
        bus.pred_valid  = pv;
        bus.pred_pc     = ppc;
        bus.pred_taken  = pt;
        bus.pred_target = ptg;
        bus.res_valid   = rv;
        bus.res_taken   = rt;
        bus.res_target  = rtg;
        bus.pipe_flush  = fl;
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic push(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        step(1'b1, pc, t, tgt, 1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic pop(input logic t, input logic [31:0] tgt);
        step(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, t, tgt, 1'b0);
    endtask

    task automatic expect_upd(input logic [31:0] pc, input logic t, input logic [31:0] tgt,
                              input logic mp, input logic [31:0] redir);
        exp_t e;
        e.pc = pc; e.taken = t; e.tgt = tgt; e.mp = mp; e.redir = redir;
        sb.push_back(e);
    endtask

    initial begin
        rst       = 1'b1;
        exp_stall = 1'b0;
        exp_uerr  = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // correct taken prediction
        push(32'h100, 1'b1, 32'h200);
        expect_upd(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        pop(1'b1, 32'h200);

        // wrong direction (NT predicted, T actual); younger entry and same-cycle push discarded
        push(32'h104, 1'b0, 32'h0);
        push(32'h10C, 1'b1, 32'h900);
        expect_upd(32'h104, 1'b1, 32'h80, 1'b1, 32'h80);
        step(1'b1, 32'h7770, 1'b0, 32'h0, 1'b1, 1'b1, 32'h80, 1'b0);
        push(32'h120, 1'b0, 32'h0);
        expect_upd(32'h120, 1'b0, 32'h0, 1'b0, 32'h0);
        pop(1'b0, 32'h0);

        // T predicted, NT actual -> fall-through redirect
        push(32'h108, 1'b1, 32'h300);
        expect_upd(32'h108, 1'b0, 32'h0, 1'b1, 32'h10C);
        pop(1'b0, 32'h0);

        // both taken, target differs
        push(32'h130, 1'b1, 32'h400);
        expect_upd(32'h130, 1'b1, 32'h404, 1'b1, 32'h404);
        pop(1'b1, 32'h404);

        // both not-taken, targets differ -> no mispredict, target still reported
        push(32'h140, 1'b0, 32'h999);
        expect_upd(32'h140, 1'b0, 32'h555, 1'b0, 32'h0);
        pop(1'b0, 32'h555);

        // fill to DEPTH, drop push when full, push+pop while full
        push(32'h200, 1'b0, 32'h0);
        push(32'h204, 1'b0, 32'h0);
        push(32'h208, 1'b0, 32'h0);
        push(32'h20C, 1'b0, 32'h0);
        exp_stall = 1'b1;
        push(32'h210, 1'b0, 32'h0);
        expect_upd(32'h200, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b1, 32'h214, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        expect_upd(32'h204, 1'b0, 32'h0, 1'b0, 32'h0);
        pop(1'b0, 32'h0);
        exp_stall = 1'b0;
        expect_upd(32'h208, 1'b0, 32'h0, 1'b0, 32'h0);
        pop(1'b0, 32'h0);
        expect_upd(32'h20C, 1'b0, 32'h0, 1'b0, 32'h0);
        pop(1'b0, 32'h0);
        expect_upd(32'h214, 1'b0, 32'h0, 1'b0, 32'h0);
        pop(1'b0, 32'h0);

        // flush with same-cycle mismatching pop: update yes, mispredict no, queue cleared
        push(32'h300, 1'b1, 32'h3A0);
        push(32'h304, 1'b0, 32'h0);
        push(32'h308, 1'b0, 32'h0);
        expect_upd(32'h300, 1'b0, 32'h44, 1'b0, 32'h0);
        step(1'b1, 32'h9999, 1'b0, 32'h0, 1'b1, 1'b0, 32'h44, 1'b1);
        push(32'h320, 1'b0, 32'h0);
        expect_upd(32'h320, 1'b0, 32'h0, 1'b0, 32'h0);
        pop(1'b0, 32'h0);

        // pop on empty with same-cycle push: underflow, push kept
        step(1'b1, 32'h400, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        exp_uerr = 1'b1;
        expect_upd(32'h400, 1'b0, 32'h0, 1'b0, 32'h0);
        pop(1'b0, 32'h0);
        repeat (3) @(posedge clk);
        #1;

        // async reset right as an update strobe rises: strobe and queue cleared
        push(32'h500, 1'b0, 32'h0);
        bus.res_valid = 1'b1;
        @(posedge clk);
        #1;
        idle_inputs();
        rst      = 1'b1;
        exp_uerr = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        pop(1'b0, 32'h0);
        exp_uerr = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        done = 1'b1;
        for (int i = 0; i < 10 && !finished; i++) @(posedge clk);
        if (!finished) begin
            $display("FAIL monitor_timeout: finished=%0b required 1", finished);
            $fatal(1, "monitor did not complete");
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
